// File: rtl/hood_mode_scheduler_if.sv
// Signal bundle between the range-hood front panel logic and the mode scheduler.
// The master drives power state and button pulses; the slave returns mode, fan and timer status.
interface hood_mode_scheduler_if;
  logic       power_on;
  logic       menu_btn;
  logic       lvl1_btn;
  logic       lvl2_btn;
  logic       lvl3_btn;
  logic       clean_btn;
  logic [2:0] mode;
  logic [1:0] fan_speed;
  logic [7:0] countdown;
  logic       lvl3_used;
  logic       clean_done;
  logic       clean_reminder;

  modport master (
    output power_on, menu_btn, lvl1_btn, lvl2_btn, lvl3_btn, clean_btn,
    input  mode, fan_speed, countdown, lvl3_used, clean_done, clean_reminder
  );

  modport slave (
    input  power_on, menu_btn, lvl1_btn, lvl2_btn, lvl3_btn, clean_btn,
    output mode, fan_speed, countdown, lvl3_used, clean_done, clean_reminder
  );
endinterface

// File: rtl/hood_mode_scheduler.sv
// Range-hood mode sequencer: standby/menu/levels, one-shot level-3 burst, forced exhaust, self-clean.
// Optional feature macro USAGE_TIMER_EN adds a fan-on usage counter that drives clean_reminder.
module hood_mode_scheduler #(
  parameter int CLK_PER_SEC = 100,
  parameter int LVL3_SEC    = 60,
  parameter int EXHAUST_SEC = 60,
  parameter int CLEAN_SEC   = 180,
  parameter int REMIND_SEC  = 36000
) (
  input logic                   clk,
  input logic                   reset,
  hood_mode_scheduler_if.slave  bus
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_STANDBY = 3'd1,
    S_MENU    = 3'd2,
    S_LVL1    = 3'd3,
    S_LVL2    = 3'd4,
    S_LVL3    = 3'd5,
    S_EXHAUST = 3'd6,
    S_CLEAN   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE, EV_MENU, EV_LVL1, EV_LVL2, EV_LVL3, EV_CLEAN
  } event_t;

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic [7:0]      r_countdown;
  logic [1:0]      r_fan;
  logic            r_lvl3Used;
  logic            r_cleanDone;

  event_t          w_event;
  state_t          w_nextState;
  logic [7:0]      w_nextCount;
  logic            w_cleanDone;
  logic            w_tick;
  logic            w_expire;

  assign w_tick   = (r_presc == PW'(CLK_PER_SEC - 1));
  assign w_expire = w_tick && (r_countdown == 8'd1);

  // Only the highest-priority pulse survives; lower ones are dropped even if it ends up ignored.
  always_comb begin
    w_event = EV_NONE;
    if (bus.menu_btn)       w_event = EV_MENU;
    else if (bus.lvl1_btn)  w_event = EV_LVL1;
    else if (bus.lvl2_btn)  w_event = EV_LVL2;
    else if (bus.lvl3_btn)  w_event = EV_LVL3;
    else if (bus.clean_btn) w_event = EV_CLEAN;
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_countdown;
    w_cleanDone = 1'b0;
    case (r_state)
      S_OFF:     w_nextState = S_STANDBY;
      S_STANDBY: if (w_event == EV_MENU) w_nextState = S_MENU;
      S_MENU: begin
        case (w_event)
          EV_MENU:  w_nextState = S_STANDBY;
          EV_LVL1:  w_nextState = S_LVL1;
          EV_LVL2:  w_nextState = S_LVL2;
          EV_LVL3: begin
            if (!r_lvl3Used) begin
              w_nextState = S_LVL3;
              w_nextCount = 8'(LVL3_SEC);
            end
          end
          EV_CLEAN: begin
            w_nextState = S_CLEAN;
            w_nextCount = 8'(CLEAN_SEC);
          end
          default: ;
        endcase
      end
      S_LVL1, S_LVL2: begin
        case (w_event)
          EV_MENU: w_nextState = S_STANDBY;
          EV_LVL1: w_nextState = S_LVL1;
          EV_LVL2: w_nextState = S_LVL2;
          default: ;
        endcase
      end
      // Leaving the burst early still needs a fixed exhaust period, so menu wins over expiry.
      S_LVL3: begin
        if (w_event == EV_MENU) begin
          w_nextState = S_EXHAUST;
          w_nextCount = 8'(EXHAUST_SEC);
        end else if (w_expire) begin
          w_nextState = S_LVL2;
          w_nextCount = 8'd0;
        end else if (w_tick) begin
          w_nextCount = r_countdown - 8'd1;
        end
      end
      S_EXHAUST: begin
        if (w_expire) begin
          w_nextState = S_STANDBY;
          w_nextCount = 8'd0;
        end else if (w_tick) begin
          w_nextCount = r_countdown - 8'd1;
        end
      end
      S_CLEAN: begin
        if (w_expire) begin
          w_nextState = S_STANDBY;
          w_nextCount = 8'd0;
          w_cleanDone = 1'b1;
        end else if (w_tick) begin
          w_nextCount = r_countdown - 8'd1;
        end
      end
      default: w_nextState = S_OFF;
    endcase
    if (!bus.power_on) begin
      w_nextState = S_OFF;
      w_nextCount = 8'd0;
      w_cleanDone = 1'b0;
    end
  end

  // The prescaler restarts on every state entry so each timed state lasts exactly N whole seconds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_OFF;
      r_presc     <= '0;
      r_countdown <= 8'd0;
      r_fan       <= 2'd0;
      r_lvl3Used  <= 1'b0;
      r_cleanDone <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_countdown <= w_nextCount;
      r_cleanDone <= w_cleanDone;
      if (!bus.power_on || (w_nextState != r_state) || w_tick) r_presc <= '0;
      else r_presc <= r_presc + 1'b1;
      case (w_nextState)
        S_LVL1:            r_fan <= 2'd1;
        S_LVL2:            r_fan <= 2'd2;
        S_LVL3, S_EXHAUST: r_fan <= 2'd3;
        default:           r_fan <= 2'd0;
      endcase
      if (!bus.power_on)              r_lvl3Used <= 1'b0;
      else if (w_nextState == S_LVL3) r_lvl3Used <= 1'b1;
    end
  end

  assign bus.mode       = r_state;
  assign bus.fan_speed  = r_fan;
  assign bus.countdown  = r_countdown;
  assign bus.lvl3_used  = r_lvl3Used;
  assign bus.clean_done = r_cleanDone;

`ifdef USAGE_TIMER_EN
  logic [15:0] r_usage;
  logic [15:0] w_usageNext;
  logic        r_reminder;

  always_comb begin
    w_usageNext = r_usage;
    if (w_cleanDone)                                       w_usageNext = 16'd0;
    else if (w_tick && (r_fan != 2'd0) && (r_usage != 16'hFFFF)) w_usageNext = r_usage + 16'd1;
  end

  // Usage survives power-off; only reset or a finished self-clean clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_usage    <= 16'd0;
      r_reminder <= 1'b0;
    end else begin
      r_usage    <= w_usageNext;
      r_reminder <= ({16'd0, w_usageNext} >= 32'(REMIND_SEC));
    end
  end

  assign bus.clean_reminder = r_reminder;
`else
  assign bus.clean_reminder = (REMIND_SEC < 0);
`endif

endmodule

// File: tb/tb_hood_mode_scheduler.sv
// Self-checking bench for hood_mode_scheduler: directed scenarios plus randomized button traffic
// compared every cycle against an elapsed-time reference model.
module tb_hood_mode_scheduler;

  localparam int CPS = 4;
  localparam int L3S = 3;
  localparam int EXS = 2;
  localparam int CLS = 5;
  localparam int REM = 5;
`ifdef USAGE_TIMER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_MENU  = 5'b00001;
  localparam logic [4:0] B_L1    = 5'b00010;
  localparam logic [4:0] B_L2    = 5'b00100;
  localparam logic [4:0] B_L3    = 5'b01000;
  localparam logic [4:0] B_CLEAN = 5'b10000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  hood_mode_scheduler_if ifc ();

  hood_mode_scheduler #(
    .CLK_PER_SEC (CPS),
    .LVL3_SEC    (L3S),
    .EXHAUST_SEC (EXS),
    .CLEAN_SEC   (CLS),
    .REMIND_SEC  (REM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference model: mode number, cycles spent in the current mode, accumulated fan-on seconds.
  int mMode, mElapsed, mUsage;
  bit mUsed, mDone;

  function automatic int durOf(input int m);
    case (m)
      5: return L3S;
      6: return EXS;
      7: return CLS;
      default: return 0;
    endcase
  endfunction

  function automatic int fanOf(input int m);
    case (m)
      3: return 1;
      4: return 2;
      5, 6: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] expVec();
    int cd;
    bit rem;
    cd  = (durOf(mMode) != 0) ? durOf(mMode) - mElapsed / CPS : 0;
    rem = REM_EN && (mUsage >= REM);
    return {3'(mMode), 2'(fanOf(mMode)), 8'(cd), mUsed, mDone, rem};
  endfunction

  function automatic logic [15:0] dutVec();
    return {ifc.mode, ifc.fan_speed, ifc.countdown, ifc.lvl3_used, ifc.clean_done, ifc.clean_reminder};
  endfunction

  task automatic modelReset();
    mMode = 0; mElapsed = 0; mUsage = 0; mUsed = 1'b0; mDone = 1'b0;
  endtask

  task automatic modelStep(input bit pwr, input logic [4:0] b);
    int  nm, ev, dur;
    bit  tickNow, expire;
    nm      = mMode;
    mDone   = 1'b0;
    dur     = durOf(mMode);
    tickNow = (mMode != 0) && (mElapsed % CPS == CPS - 1);
    if (tickNow && fanOf(mMode) != 0 && mUsage < 65535) mUsage++;
    expire = (dur != 0) && (mElapsed + 1 == dur * CPS);
    ev = 0;
    for (int i = 4; i >= 0; i--) if (b[i]) ev = i + 1;
    if (!pwr) begin
      mMode = 0; mElapsed = 0; mUsed = 1'b0;
    end else begin
      case (mMode)
        0: nm = 1;
        1: if (ev == 1) nm = 2;
        2: case (ev)
             1: nm = 1;
             2: nm = 3;
             3: nm = 4;
             4: if (!mUsed) nm = 5;
             5: nm = 7;
             default: ;
           endcase
        3, 4: case (ev)
             1: nm = 1;
             2: nm = 3;
             3: nm = 4;
             default: ;
           endcase
        5: if (ev == 1) nm = 6; else if (expire) nm = 4;
        6: if (expire) nm = 1;
        7: if (expire) begin nm = 1; mDone = 1'b1; end
        default: ;
      endcase
      if (nm != mMode) begin
        mElapsed = 0;
        if (nm == 5) mUsed = 1'b1;
      end else begin
        mElapsed++;
      end
      mMode = nm;
    end
    if (mDone) mUsage = 0;
  endtask

  task automatic applyStimulus(input bit pwr, input logic [4:0] b);
    ifc.power_on  = pwr;
    ifc.menu_btn  = b[0];
    ifc.lvl1_btn  = b[1];
    ifc.lvl2_btn  = b[2];
    ifc.lvl3_btn  = b[3];
    ifc.clean_btn = b[4];
    @(posedge clk);
    modelStep(pwr, b);
    #1;
    ifc.menu_btn = 1'b0; ifc.lvl1_btn = 1'b0; ifc.lvl2_btn = 1'b0;
    ifc.lvl3_btn = 1'b0; ifc.clean_btn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, B_NONE);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.power_on = 1'b0;
    ifc.menu_btn = 1'b0; ifc.lvl1_btn = 1'b0; ifc.lvl2_btn = 1'b0;
    ifc.lvl3_btn = 1'b0; ifc.clean_btn = 1'b0;
    modelReset();
    #2;
    checks++;
    if (dutVec() !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_outputs got=%h exp=%h", dutVec(), 16'h0000);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(1'b0, B_MENU);
    checks++;
    if (ifc.mode !== 3'd0) begin
      errors++; $display("[TB] FAIL off_holds mode got=%0d exp=0", ifc.mode);
    end
  endtask

  task automatic test_levels();
    logic [4:0] btns [4] = '{B_MENU, B_L2, B_L1, B_MENU};
    logic [2:0] modes[4] = '{3'd2, 3'd4, 3'd3, 3'd1};
    logic [1:0] fans [4] = '{2'd0, 2'd2, 2'd1, 2'd0};
    applyStimulus(1'b1, B_NONE);
    checks++;
    if ({ifc.mode, ifc.fan_speed} !== {3'd1, 2'd0}) begin
      errors++; $display("[TB] FAIL power_up mode/fan got=%0d/%0d exp=1/0", ifc.mode, ifc.fan_speed);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, btns[i]);
      checks++;
      if ({ifc.mode, ifc.fan_speed} !== {modes[i], fans[i]}) begin
        errors++;
        $display("[TB] FAIL levels_step%0d mode/fan got=%0d/%0d exp=%0d/%0d",
                 i, ifc.mode, ifc.fan_speed, modes[i], fans[i]);
      end
    end
  endtask

  task automatic test_lvl3_burst();
    applyStimulus(1'b1, B_MENU);
    applyStimulus(1'b1, B_L3);
    checks++;
    if ({ifc.mode, ifc.fan_speed, ifc.countdown, ifc.lvl3_used} !== {3'd5, 2'd3, 8'd3, 1'b1}) begin
      errors++; $display("[TB] FAIL lvl3_entry mode/fan/cd/used got=%0d/%0d/%0d/%0d exp=5/3/3/1",
                         ifc.mode, ifc.fan_speed, ifc.countdown, ifc.lvl3_used);
    end
    idle(3);
    checks++;
    if (ifc.countdown !== 8'd3) begin
      errors++; $display("[TB] FAIL lvl3_cd_3cyc got=%0d exp=3", ifc.countdown);
    end
    idle(1);
    checks++;
    if (ifc.countdown !== 8'd2) begin
      errors++; $display("[TB] FAIL lvl3_cd_4cyc got=%0d exp=2", ifc.countdown);
    end
    idle(4);
    checks++;
    if (ifc.countdown !== 8'd1) begin
      errors++; $display("[TB] FAIL lvl3_cd_8cyc got=%0d exp=1", ifc.countdown);
    end
    idle(3);
    checks++;
    if (ifc.mode !== 3'd5) begin
      errors++; $display("[TB] FAIL lvl3_still_11cyc mode got=%0d exp=5", ifc.mode);
    end
    idle(1);
    checks++;
    if ({ifc.mode, ifc.fan_speed, ifc.countdown} !== {3'd4, 2'd2, 8'd0}) begin
      errors++; $display("[TB] FAIL lvl3_expire mode/fan/cd got=%0d/%0d/%0d exp=4/2/0",
                         ifc.mode, ifc.fan_speed, ifc.countdown);
    end
  endtask

  task automatic test_exhaust();
    applyStimulus(1'b0, B_NONE);
    checks++;
    if ({ifc.mode, ifc.lvl3_used, ifc.countdown} !== {3'd0, 1'b0, 8'd0}) begin
      errors++; $display("[TB] FAIL poweroff mode/used/cd got=%0d/%0d/%0d exp=0/0/0",
                         ifc.mode, ifc.lvl3_used, ifc.countdown);
    end
    applyStimulus(1'b1, B_NONE);
    applyStimulus(1'b1, B_MENU);
    applyStimulus(1'b1, B_L3);
    idle(4);
    applyStimulus(1'b1, B_MENU);
    checks++;
    if ({ifc.mode, ifc.fan_speed, ifc.countdown} !== {3'd6, 2'd3, 8'd2}) begin
      errors++; $display("[TB] FAIL exhaust_entry mode/fan/cd got=%0d/%0d/%0d exp=6/3/2",
                         ifc.mode, ifc.fan_speed, ifc.countdown);
    end
    idle(7);
    checks++;
    if ({ifc.mode, ifc.countdown} !== {3'd6, 8'd1}) begin
      errors++; $display("[TB] FAIL exhaust_7cyc mode/cd got=%0d/%0d exp=6/1", ifc.mode, ifc.countdown);
    end
    idle(1);
    checks++;
    if ({ifc.mode, ifc.fan_speed, ifc.countdown} !== {3'd1, 2'd0, 8'd0}) begin
      errors++; $display("[TB] FAIL exhaust_expire mode/fan/cd got=%0d/%0d/%0d exp=1/0/0",
                         ifc.mode, ifc.fan_speed, ifc.countdown);
    end
    applyStimulus(1'b1, B_MENU);
    applyStimulus(1'b1, B_L3);
    checks++;
    if (ifc.mode !== 3'd2) begin
      errors++; $display("[TB] FAIL lvl3_once mode got=%0d exp=2", ifc.mode);
    end
    applyStimulus(1'b0, B_NONE);
    applyStimulus(1'b1, B_NONE);
    applyStimulus(1'b1, B_MENU);
    applyStimulus(1'b1, B_L3);
    checks++;
    if (ifc.mode !== 3'd5) begin
      errors++; $display("[TB] FAIL lvl3_after_powercycle mode got=%0d exp=5", ifc.mode);
    end
  endtask

  task automatic test_clean();
    applyStimulus(1'b1, B_MENU);
    idle(8);
    applyStimulus(1'b1, B_MENU);
    applyStimulus(1'b1, B_CLEAN);
    checks++;
    if ({ifc.mode, ifc.fan_speed, ifc.countdown} !== {3'd7, 2'd0, 8'd5}) begin
      errors++; $display("[TB] FAIL clean_entry mode/fan/cd got=%0d/%0d/%0d exp=7/0/5",
                         ifc.mode, ifc.fan_speed, ifc.countdown);
    end
    idle(19);
    checks++;
    if ({ifc.mode, ifc.countdown, ifc.clean_done} !== {3'd7, 8'd1, 1'b0}) begin
      errors++; $display("[TB] FAIL clean_19cyc mode/cd/done got=%0d/%0d/%0d exp=7/1/0",
                         ifc.mode, ifc.countdown, ifc.clean_done);
    end
    idle(1);
    checks++;
    if ({ifc.mode, ifc.clean_done} !== {3'd1, 1'b1}) begin
      errors++; $display("[TB] FAIL clean_finish mode/done got=%0d/%0d exp=1/1", ifc.mode, ifc.clean_done);
    end
    idle(1);
    checks++;
    if (ifc.clean_done !== 1'b0) begin
      errors++; $display("[TB] FAIL clean_done_width got=%0d exp=0", ifc.clean_done);
    end
    applyStimulus(1'b1, B_MENU);
    applyStimulus(1'b1, B_CLEAN);
    idle(9);
    applyStimulus(1'b0, B_NONE);
    checks++;
    if ({ifc.mode, ifc.countdown, ifc.clean_done} !== {3'd0, 8'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL clean_abort mode/cd/done got=%0d/%0d/%0d exp=0/0/0",
                         ifc.mode, ifc.countdown, ifc.clean_done);
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, B_NONE);
      checks++;
      if (ifc.clean_done !== 1'b0) begin
        errors++; $display("[TB] FAIL clean_abort_nodone cyc%0d got=%0d exp=0", i, ifc.clean_done);
      end
    end
  endtask

  task automatic test_priority();
    applyStimulus(1'b1, B_NONE);
    applyStimulus(1'b1, B_MENU);
    applyStimulus(1'b1, B_MENU | B_L1);
    checks++;
    if (ifc.mode !== 3'd1) begin
      errors++; $display("[TB] FAIL prio_menu_over_l1 mode got=%0d exp=1", ifc.mode);
    end
    applyStimulus(1'b1, B_MENU);
    applyStimulus(1'b1, B_L1 | B_L2 | B_CLEAN);
    checks++;
    if (ifc.mode !== 3'd3) begin
      errors++; $display("[TB] FAIL prio_l1_over_l2 mode got=%0d exp=3", ifc.mode);
    end
    applyStimulus(1'b1, B_MENU);
    applyStimulus(1'b1, B_MENU);
    applyStimulus(1'b1, B_L3);
    applyStimulus(1'b1, B_L1);
    checks++;
    if ({ifc.mode, ifc.countdown} !== {3'd5, 8'd3}) begin
      errors++; $display("[TB] FAIL lvl3_ignores_l1 mode/cd got=%0d/%0d exp=5/3", ifc.mode, ifc.countdown);
    end
  endtask

  task automatic test_reset_midrun();
    applyStimulus(1'b1, B_MENU);
    idle(8);
    applyStimulus(1'b1, B_MENU);
    applyStimulus(1'b1, B_L1);
    checks++;
    if ({ifc.mode, ifc.fan_speed} !== {3'd3, 2'd1}) begin
      errors++; $display("[TB] FAIL lvl1_before_reset mode/fan got=%0d/%0d exp=3/1", ifc.mode, ifc.fan_speed);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (dutVec() !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_async got=%h exp=%h", dutVec(), 16'h0000);
    end
    modelReset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_usage();
    bit expRem;
    expRem = REM_EN;
    applyStimulus(1'b1, B_NONE);
    applyStimulus(1'b1, B_MENU);
    applyStimulus(1'b1, B_L1);
    idle(19);
    checks++;
    if (ifc.clean_reminder !== 1'b0) begin
      errors++; $display("[TB] FAIL usage_19cyc reminder got=%0d exp=0", ifc.clean_reminder);
    end
    idle(1);
    checks++;
    if (ifc.clean_reminder !== expRem) begin
      errors++; $display("[TB] FAIL usage_20cyc reminder got=%0d exp=%0d", ifc.clean_reminder, expRem);
    end
    applyStimulus(1'b1, B_MENU);
    applyStimulus(1'b1, B_MENU);
    applyStimulus(1'b1, B_CLEAN);
    idle(20);
    checks++;
    if ({ifc.clean_done, ifc.clean_reminder} !== {1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL usage_cleared done/reminder got=%0d/%0d exp=1/0",
                         ifc.clean_done, ifc.clean_reminder);
    end
  endtask

  task automatic test_random();
    bit         pwr;
    logic [4:0] b;
    reset = 1'b1;
    modelReset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      pwr = ($urandom_range(0, 299) != 0);
      b   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : B_NONE;
      applyStimulus(pwr, b);
      checks++;
      if (dutVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL random_cyc%0d {mode,fan,cd,used,done,rem} got=%h exp=%h", i, dutVec(), expVec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_levels();
    test_lvl3_burst();
    test_exhaust();
    test_clean();
    test_priority();
    test_reset_midrun();
    test_usage();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
